// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the hazard control unit:
// forwarding selects, FSM state encoding and the hard-wired zero register.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } hz_state_t;

    localparam logic [4:0] REG_ZERO = 5'd0;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side bundle for the hazard unit.
// The pipeline (master) supplies register indices and controls; the hazard unit (slave) returns steering.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [4:0]       id_rs;
    logic [4:0]       id_rt;
    logic             id_uses_rt;
    logic             ex_mem_read;
    logic [4:0]       ex_rs;
    logic [4:0]       ex_rt;
    logic             ex_beq;
    logic             ex_bne;
    logic             ex_j;
    logic             ex_zero;
    logic             mem_reg_write;
    logic [4:0]       mem_dest;
    logic             wb_reg_write;
    logic [4:0]       wb_dest;

    logic             pc_write;
    logic             if_id_write;
    logic             if_id_flush;
    logic             id_exe_bubble;
    logic             pc_redirect;
    logic [1:0]       fwd_a;
    logic [1:0]       fwd_b;
    logic [CNT_W-1:0] stall_count;
    logic [CNT_W-1:0] flush_count;

    modport master (
        output id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rs, ex_rt,
               ex_beq, ex_bne, ex_j, ex_zero,
               mem_reg_write, mem_dest, wb_reg_write, wb_dest,
        input  pc_write, if_id_write, if_id_flush, id_exe_bubble, pc_redirect,
               fwd_a, fwd_b, stall_count, flush_count
    );

    modport slave (
        input  id_rs, id_rt, id_uses_rt, ex_mem_read, ex_rs, ex_rt,
               ex_beq, ex_bne, ex_j, ex_zero,
               mem_reg_write, mem_dest, wb_reg_write, wb_dest,
        output pc_write, if_id_write, if_id_flush, id_exe_bubble, pc_redirect,
               fwd_a, fwd_b, stall_count, flush_count
    );

endinterface

// File: rtl/hazard_ctrl_fwd_select.sv
// Operand forwarding select for one ALU source.
// The youngest producer (EX/MEM) wins over MEM/WB; writes to $0 are never forwarded.
module fwd_select
    import hazard_ctrl_pkg::*;
(
    input  logic [4:0] src,
    input  logic       mem_reg_write,
    input  logic [4:0] mem_dest,
    input  logic       wb_reg_write,
    input  logic [4:0] wb_dest,
    output fwd_sel_t   sel
);

    always_comb begin
        sel = FWD_RF;
        if (mem_reg_write && (mem_dest != REG_ZERO) && (mem_dest == src)) begin
            sel = FWD_MEM;
        end else if (wb_reg_write && (wb_dest != REG_ZERO) && (wb_dest == src)) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Hazard control: load-use stalls, taken-transfer flush sequencing, operand forwarding
// and saturating stall/flush event counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int CNT_W        = 16,
    parameter int FLUSH_CYCLES = 1
) (
    input  logic          clk,
    input  logic          rst,
    hazard_ctrl_if.slave  hz
);

    localparam bit               MULTI_FLUSH = (FLUSH_CYCLES > 1);
    localparam logic [1:0]       FLUSH_INIT  = 2'(FLUSH_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX     = '1;
    localparam logic [CNT_W-1:0] CNT_ONE     = CNT_W'(1);

    hz_state_t        state, state_next;
    logic [1:0]       flush_left, flush_left_next;
    logic [CNT_W-1:0] stall_count, flush_count;
    logic             stall_inc, flush_inc;
    logic             taken, load_use;
    fwd_sel_t         fwd_a_sel, fwd_b_sel;

    assign taken    = hz.ex_j | (hz.ex_beq & hz.ex_zero) | (hz.ex_bne & ~hz.ex_zero);
    assign load_use = hz.ex_mem_read & (hz.ex_rt != REG_ZERO) &
                      ((hz.ex_rt == hz.id_rs) | (hz.id_uses_rt & (hz.ex_rt == hz.id_rt)));

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= RUN;
            flush_left  <= 2'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            state      <= state_next;
            flush_left <= flush_left_next;
            if (stall_inc && (stall_count != CNT_MAX)) stall_count <= stall_count + CNT_ONE;
            if (flush_inc && (flush_count != CNT_MAX)) flush_count <= flush_count + CNT_ONE;
        end
    end

    // A taken transfer outranks a load-use hit because the ID instruction is wrong-path.
    always_comb begin
        state_next       = state;
        flush_left_next  = flush_left;
        hz.pc_write      = 1'b1;
        hz.if_id_write   = 1'b1;
        hz.if_id_flush   = 1'b0;
        hz.id_exe_bubble = 1'b0;
        hz.pc_redirect   = 1'b0;
        stall_inc        = 1'b0;
        flush_inc        = 1'b0;
        case (state)
            RUN: begin
                if (taken) begin
                    hz.pc_redirect   = 1'b1;
                    hz.if_id_flush   = 1'b1;
                    hz.id_exe_bubble = 1'b1;
                    flush_inc        = 1'b1;
                    if (MULTI_FLUSH) begin
                        state_next      = FLUSH;
                        flush_left_next = FLUSH_INIT;
                    end
                end else if (load_use) begin
                    hz.pc_write      = 1'b0;
                    hz.if_id_write   = 1'b0;
                    hz.id_exe_bubble = 1'b1;
                    stall_inc        = 1'b1;
                end
            end
            FLUSH: begin
                hz.if_id_flush   = 1'b1;
                hz.id_exe_bubble = 1'b1;
                flush_left_next  = flush_left - 2'd1;
                if (flush_left == 2'd1) state_next = RUN;
            end
            default: begin
                state_next      = RUN;
                flush_left_next = 2'd0;
            end
        endcase
        if (!rst) begin
            hz.pc_write      = 1'b0;
            hz.if_id_write   = 1'b0;
            hz.if_id_flush   = 1'b0;
            hz.id_exe_bubble = 1'b0;
            hz.pc_redirect   = 1'b0;
        end
    end

    fwd_select u_fwd_a (
        .src           (hz.ex_rs),
        .mem_reg_write (hz.mem_reg_write),
        .mem_dest      (hz.mem_dest),
        .wb_reg_write  (hz.wb_reg_write),
        .wb_dest       (hz.wb_dest),
        .sel           (fwd_a_sel)
    );

    fwd_select u_fwd_b (
        .src           (hz.ex_rt),
        .mem_reg_write (hz.mem_reg_write),
        .mem_dest      (hz.mem_dest),
        .wb_reg_write  (hz.wb_reg_write),
        .wb_dest       (hz.wb_dest),
        .sel           (fwd_b_sel)
    );

    assign hz.fwd_a       = rst ? fwd_a_sel : FWD_RF;
    assign hz.fwd_b       = rst ? fwd_b_sel : FWD_RF;
    assign hz.stall_count = stall_count;
    assign hz.flush_count = flush_count;

endmodule
